// File: rtl/aes512_block_packer.sv
// Packs 16 upstream 32-bit words (first word most significant) into one 512-bit block for the encryption datapath.
// Latency: m_valid rises on the edge accepting the final word; release returns s_ready=1 the following cycle.
// Backpressure: s_ready drops while a block is held; the block stays frozen until m_ready. Option: AES512_PACK_PAD_EN (s_last closes a short block).
module aes512_block_packer #(
    parameter int WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORDS*32-1:0]   m_block,
    output logic [4:0]            m_words
);

    localparam int BLOCK_W = WORDS * 32;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [BLOCK_W-1:0]   buf_q, buf_d;
    logic [4:0]           words_q, words_d;
    logic                 m_valid_q, m_valid_d;

    logic                 accept;
    logic                 last_slot;
    logic                 close_blk;

`ifdef AES512_PACK_PAD_EN
    logic                 early_close;
    assign early_close = s_last;
`else
    logic                 unused_s_last;
    assign unused_s_last = s_last;
`endif

    assign last_slot = (cnt_q == 4'(WORDS - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        words_d   = words_q;
        m_valid_d = m_valid_q;
        accept    = 1'b0;
        close_blk = 1'b0;

        case (state_q)
            FILL: begin
                accept = s_valid;
                if (accept) begin
                    // Word k lands at the top of the block and walks down.
                    buf_d[(WORDS - 1 - int'(cnt_q)) * 32 +: 32] = s_data;
                    cnt_d = cnt_q + 4'd1;
                    if (last_slot) begin
                        close_blk = 1'b1;
                        words_d   = 5'(WORDS);
                    end
`ifdef AES512_PACK_PAD_EN
                    else if (early_close) begin
                        // Remaining slots are already zero from the last release/reset.
                        close_blk = 1'b1;
                        words_d   = {1'b0, cnt_q} + 5'd1;
                    end
`endif
                    if (close_blk) begin
                        state_d   = HOLD;
                        cnt_d     = 4'd0;
                        m_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_valid_q && m_ready) begin
                    state_d   = FILL;
                    buf_d     = '0;
                    words_d   = 5'd0;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = FILL;
                cnt_d     = 4'd0;
                buf_d     = '0;
                words_d   = 5'd0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= 4'd0;
            buf_q     <= '0;
            words_q   <= 5'd0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            words_q   <= words_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign s_ready = (state_q == FILL);
    assign m_valid = m_valid_q;
    assign m_block = buf_q;
    assign m_words = words_q;

endmodule

// File: tb/tb_aes512_block_packer.sv
// Directed bench for aes512_block_packer: reset, full block, backpressure, stalls, padding option, mid-fill/mid-hold reset.
module tb_aes512_block_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [511:0] m_block;
    logic [4:0]   m_words;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aes512_block_packer #(.WORDS(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_block (m_block),
        .m_words (m_words)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and returns just after the edge that accepts it.
    task automatic send(input logic [31:0] d, input logic last);
        int budget;
        budget  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) check("send_timeout", 512'(s_ready), 512'(1'b1));
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s_ready"}, 512'(s_ready), 512'(1'b1));
        check({tag, "_m_valid"}, 512'(m_valid), 512'(1'b0));
        check({tag, "_m_block"}, m_block, 512'h0);
        check({tag, "_m_words"}, 512'(m_words), 512'(5'd0));
    endtask

    logic [511:0] seq_blk;
    logic [511:0] str_blk;
    logic [511:0] pad_blk;
    logic [511:0] nopad_blk;
    logic [511:0] new_blk;

    initial begin
        seq_blk   = 512'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008_00000009_0000000a_0000000b_0000000c_0000000d_0000000e_0000000f_00000010;
        str_blk   = {"we atlast finished..lets wrap up", 256'h0};
        pad_blk   = {32'h000000a0, 32'h000000a1, 32'h000000a2, 32'h000000a3, 32'h000000a4, 352'h0};
        nopad_blk = 512'h000000a0_000000a1_000000a2_000000a3_000000a4_000000b0_000000b1_000000b2_000000b3_000000b4_000000b5_000000b6_000000b7_000000b8_000000b9_000000ba;
        new_blk   = 512'h00000100_00000101_00000102_00000103_00000104_00000105_00000106_00000107_00000108_00000109_0000010a_0000010b_0000010c_0000010d_0000010e_0000010f;

        // Reset with random inputs toggling.
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'($urandom);
            s_data  = $urandom;
            s_last  = 1'($urandom);
            m_ready = 1'($urandom);
            tick();
        end
        check_idle("reset");
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Full block, consumer always ready.
        m_ready = 1'b1;
        for (int k = 0; k < 15; k++) send(32'(k + 1), 1'b0);
        check("full_no_valid_at_15", 512'(m_valid), 512'(1'b0));
        send(32'h10, 1'b0);
        check("full_m_valid", 512'(m_valid), 512'(1'b1));
        check("full_s_ready_low", 512'(s_ready), 512'(1'b0));
        check("full_block", m_block, seq_blk);
        check("full_top_word", 512'(m_block[511:480]), 512'(32'h1));
        check("full_bottom_word", 512'(m_block[31:0]), 512'(32'h10));
        check("full_words", 512'(m_words), 512'(5'd16));
        tick();
        check_idle("full_release");

        // Backpressure: hold for 10 cycles while upstream keeps offering junk.
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(str_blk[511 - 32*k -: 32], 1'b0);
        check("bp_block", m_block, str_blk);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            tick();
            check("bp_s_ready", 512'(s_ready), 512'(1'b0));
            check("bp_m_valid", 512'(m_valid), 512'(1'b1));
            check("bp_stable", m_block, str_blk);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check_idle("bp_release");

        // Input stalls with the consumer stalled too.
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 3)) begin
                s_data = $urandom;
                tick();
            end
            send(32'(k + 1), 1'b0);
        end
        check("stall_block", m_block, seq_blk);
        check("stall_words", 512'(m_words), 512'(5'd16));
        m_ready = 1'b1;
        tick();
        check_idle("stall_release");

        // Short message with s_last on the fifth word.
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(32'hA0 + 32'(k), k == 4);
`ifdef AES512_PACK_PAD_EN
        check("pad_m_valid", 512'(m_valid), 512'(1'b1));
        check("pad_words", 512'(m_words), 512'(5'd5));
        check("pad_block", m_block, pad_blk);
`else
        check("nopad_m_valid_5", 512'(m_valid), 512'(1'b0));
        check("nopad_partial", m_block, pad_blk);
        for (int k = 0; k < 10; k++) send(32'hB0 + 32'(k), 1'b0);
        check("nopad_m_valid_15", 512'(m_valid), 512'(1'b0));
        send(32'hBA, 1'b0);
        check("nopad_m_valid", 512'(m_valid), 512'(1'b1));
        check("nopad_words", 512'(m_words), 512'(5'd16));
        check("nopad_block", m_block, nopad_blk);
`endif
        m_ready = 1'b1;
        tick();
        check_idle("pad_release");

        // Reset mid-fill discards partial words; async reset acts before any edge.
        m_ready = 1'b0;
        for (int k = 0; k < 7; k++) send(32'hDEAD0000 + 32'(k), 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle("midfill_reset");
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) send(32'h100 + 32'(k), 1'b0);
        check("midfill_new_block", m_block, new_blk);
        check("midfill_words", 512'(m_words), 512'(5'd16));

        // Reset while holding drops the held block.
        rst_n = 1'b0;
        #1;
        check_idle("midhold_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("midhold_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
